// File: rtl/axil_axis_pkg.sv
// axil_axis_pkg: register map, response codes and FSM states shared by the AXI-Lite/AXIS bridge.
package axil_axis_pkg;
  localparam int unsigned REG_DATA = 'h0;
  localparam int unsigned REG_STATUS = 'h4;
  localparam int unsigned REG_CTRL = 'h8;
  localparam int unsigned REG_IRQ_EN = 'hC;
  typedef enum logic [1:0] {OKAY = 2'd0, SLVERR = 2'd2, DECERR = 2'd3} resp_t;
  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;
endpackage

// File: rtl/axil_axis_fifo.sv
// axil_axis_fifo: synchronous FIFO with flush; full/empty come from pre-cycle state.
module axil_axis_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic flush,
  input logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & !full & !flush;
  assign do_pop = pop & !empty & !flush;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/axil_axis_bridge.sv
// axil_axis_bridge: AXI4-Lite slave feeding a TX stream FIFO and draining an RX stream FIFO.
// Define AXIL_AXIS_IRQ_EN to add the irq output and the IRQ_EN register at 0xC.
module axil_axis_bridge
  import axil_axis_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input logic aclk,
  input logic areset,
  input logic [ADDR_W-1:0] s_axi_awaddr,
  input logic s_axi_awvalid,
  output logic s_axi_awready,
  input logic [DATA_W-1:0] s_axi_wdata,
  input logic [DATA_W/8-1:0] s_axi_wstrb,
  input logic s_axi_wvalid,
  output logic s_axi_wready,
  output logic [1:0] s_axi_bresp,
  output logic s_axi_bvalid,
  input logic s_axi_bready,
  input logic [ADDR_W-1:0] s_axi_araddr,
  input logic s_axi_arvalid,
  output logic s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0] s_axi_rresp,
  output logic s_axi_rvalid,
  input logic s_axi_rready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic m_axis_tvalid,
  input logic m_axis_tready,
  input logic [DATA_W-1:0] s_axis_tdata,
  input logic s_axis_tvalid,
  output logic s_axis_tready
`ifdef AXIL_AXIS_IRQ_EN
  ,
  output logic irq
`endif
);
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  localparam int IW = ADDR_W - 2;
  localparam logic [IW-1:0] I_DATA = IW'(REG_DATA >> 2);
  localparam logic [IW-1:0] I_STATUS = IW'(REG_STATUS >> 2);
  localparam logic [IW-1:0] I_CTRL = IW'(REG_CTRL >> 2);
  wstate_t wstate;
  rstate_t rstate;
  resp_t wr_resp, rd_resp;
  logic live;
  logic [IW-1:0] widx, ridx;
  logic wr_fire, rd_fire;
  logic w_data, w_status, w_ctrl, w_irq, r_data, r_status, r_ctrl, r_irq;
  logic tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [TCW-1:0] tx_count;
  logic [RCW-1:0] rx_count;
  logic [DATA_W-1:0] rx_dout, status, rd_data, irq_en_v;
  logic unused_ok;
  assign unused_ok = ^{s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  // Handshake readies stay low until the first clock after reset release.
  always_ff @(posedge aclk or posedge areset)
    if (areset) live <= 1'b0;
    else live <= 1'b1;
  assign widx = s_axi_awaddr[ADDR_W-1:2];
  assign ridx = s_axi_araddr[ADDR_W-1:2];
  assign w_data = widx == I_DATA;
  assign w_status = widx == I_STATUS;
  assign w_ctrl = widx == I_CTRL;
  assign r_data = ridx == I_DATA;
  assign r_status = ridx == I_STATUS;
  assign r_ctrl = ridx == I_CTRL;
  assign wr_fire = live && wstate == W_IDLE && s_axi_awvalid && s_axi_wvalid;
  assign s_axi_awready = wr_fire;
  assign s_axi_wready = wr_fire;
  assign s_axi_arready = live && rstate == R_IDLE;
  assign rd_fire = s_axi_arready & s_axi_arvalid;
  assign status = DATA_W'({16'(TX_DEPTH) - 16'(tx_count), 16'(rx_count)});
  always_comb begin
    wr_resp = w_data ? (tx_full ? SLVERR : OKAY) : (w_status | w_ctrl | w_irq) ? OKAY : DECERR;
    rd_resp = r_data ? (rx_empty ? SLVERR : OKAY) : (r_status | r_ctrl | r_irq) ? OKAY : DECERR;
    rd_data = (r_data & !rx_empty) ? rx_dout : r_status ? status : r_irq ? irq_en_v : '0;
  end
  assign tx_push = wr_fire & w_data & !tx_full;
  assign tx_flush = wr_fire & w_ctrl & s_axi_wdata[0];
  assign rx_flush = wr_fire & w_ctrl & s_axi_wdata[1];
  assign m_axis_tvalid = !tx_empty & !tx_flush;
  assign tx_pop = m_axis_tvalid & m_axis_tready;
  assign s_axis_tready = live & !rx_full;
  assign rx_push = s_axis_tvalid & s_axis_tready;
  assign rx_pop = rd_fire & r_data;
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      wstate <= W_IDLE;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp <= OKAY;
    end else if (wstate == W_IDLE) begin
      if (wr_fire) begin
        wstate <= W_RESP;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp <= wr_resp;
      end
    end else if (s_axi_bready) begin
      wstate <= W_IDLE;
      s_axi_bvalid <= 1'b0;
    end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      rstate <= R_IDLE;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp <= OKAY;
      s_axi_rdata <= '0;
    end else if (rstate == R_IDLE) begin
      if (rd_fire) begin
        rstate <= R_RESP;
        s_axi_rvalid <= 1'b1;
        s_axi_rresp <= rd_resp;
        s_axi_rdata <= rd_data;
      end
    end else if (s_axi_rready) begin
      rstate <= R_IDLE;
      s_axi_rvalid <= 1'b0;
    end
`ifdef AXIL_AXIS_IRQ_EN
  localparam logic [IW-1:0] I_IRQ = IW'(REG_IRQ_EN >> 2);
  logic [1:0] irq_en;
  assign w_irq = widx == I_IRQ;
  assign r_irq = ridx == I_IRQ;
  assign irq_en_v = DATA_W'(irq_en);
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      irq_en <= 2'b00;
      irq <= 1'b0;
    end else begin
      if (wr_fire & w_irq) irq_en <= s_axi_wdata[1:0];
      irq <= (irq_en[0] & !rx_empty) | (irq_en[1] & tx_empty);
    end
`else
  assign w_irq = 1'b0;
  assign r_irq = 1'b0;
  assign irq_en_v = '0;
`endif
  axil_axis_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx (
    .clk(aclk),
    .rst(areset),
    .push(tx_push),
    .pop(tx_pop),
    .flush(tx_flush),
    .din(s_axi_wdata),
    .dout(m_axis_tdata),
    .full(tx_full),
    .empty(tx_empty),
    .count(tx_count)
  );
  axil_axis_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx (
    .clk(aclk),
    .rst(areset),
    .push(rx_push),
    .pop(rx_pop),
    .flush(rx_flush),
    .din(s_axis_tdata),
    .dout(rx_dout),
    .full(rx_full),
    .empty(rx_empty),
    .count(rx_count)
  );
endmodule

// File: tb/tb_axil_axis_bridge.sv
// tb_axil_axis_bridge: directed checks of the AXI-Lite/AXIS bridge at default parameters.
module tb_axil_axis_bridge;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic [3:0] s_axi_awaddr = '0;
  logic s_axi_awvalid = 1'b0;
  logic s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0] s_axi_wstrb = 4'hF;
  logic s_axi_wvalid = 1'b0;
  logic s_axi_wready;
  logic [1:0] s_axi_bresp;
  logic s_axi_bvalid;
  logic s_axi_bready = 1'b0;
  logic [3:0] s_axi_araddr = '0;
  logic s_axi_arvalid = 1'b0;
  logic s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0] s_axi_rresp;
  logic s_axi_rvalid;
  logic s_axi_rready = 1'b0;
  logic [31:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tready = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tready;
`ifdef AXIL_AXIS_IRQ_EN
  logic irq;
`endif
  int checks = 0;
  int errors = 0;
  logic [31:0] tx_seen [$];

  always #5 aclk = ~aclk;

  axil_axis_bridge dut (
    .aclk(aclk),
    .areset(areset),
    .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready)
`ifdef AXIL_AXIS_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  // TX transfers complete on the next rising edge; inputs only change just after rising edges.
  always @(negedge aclk)
    if (m_axis_tvalid && m_axis_tready) tx_seen.push_back(m_axis_tdata);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, output logic [1:0] r);
    int n;
    n = 0;
    @(posedge aclk); #1;
    s_axi_awaddr = a;
    s_axi_wdata = d;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid = 1'b1;
    #1;
    while (!s_axi_awready && n < 20) begin @(posedge aclk); #2; n++; end
    if (!s_axi_awready) begin
      checks++; errors++;
      $display("FAIL aw_timeout: awready=%b, required 1", s_axi_awready);
    end
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (!s_axi_bvalid) begin
      checks++; errors++;
      $display("FAIL b_timeout: bvalid=%b, required 1", s_axi_bvalid);
    end
    r = s_axi_bresp;
    s_axi_bready = 1'b1;
    @(posedge aclk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    n = 0;
    @(posedge aclk); #1;
    s_axi_araddr = a;
    s_axi_arvalid = 1'b1;
    #1;
    while (!s_axi_arready && n < 20) begin @(posedge aclk); #2; n++; end
    if (!s_axi_arready) begin
      checks++; errors++;
      $display("FAIL ar_timeout: arready=%b, required 1", s_axi_arready);
    end
    @(posedge aclk); #1;
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (!s_axi_rvalid) begin
      checks++; errors++;
      $display("FAIL r_timeout: rvalid=%b, required 1", s_axi_rvalid);
    end
    d = s_axi_rdata;
    r = s_axi_rresp;
    s_axi_rready = 1'b1;
    @(posedge aclk); #1;
    s_axi_rready = 1'b0;
  endtask

  task automatic rx_send(input logic [31:0] d);
    int n;
    n = 0;
    @(posedge aclk); #1;
    s_axis_tdata = d;
    s_axis_tvalid = 1'b1;
    #1;
    while (!s_axis_tready && n < 20) begin @(posedge aclk); #2; n++; end
    if (!s_axis_tready) begin
      checks++; errors++;
      $display("FAIL rx_timeout: s_axis_tready=%b, required 1", s_axis_tready);
    end
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, m_axis_tvalid,
         s_axis_tready, s_axi_bresp, s_axi_rresp} !== 11'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 0", {s_axi_awready, s_axi_wready, s_axi_bvalid,
               s_axi_arready, s_axi_rvalid, m_axis_tvalid, s_axis_tready, s_axi_bresp, s_axi_rresp});
    end
    checks++;
    if (s_axi_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h, required 0", s_axi_rdata);
    end
    areset = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if ({s_axi_arready, s_axis_tready, m_axis_tvalid} !== 3'b110) begin
      errors++;
      $display("FAIL post_reset: got %b, required 110", {s_axi_arready, s_axis_tready, m_axis_tvalid});
    end
  endtask

  task automatic test_tx_single();
    logic [1:0] r;
    logic [31:0] first;
    m_axis_tready = 1'b1;
    tx_seen.delete();
    axi_write(4'h0, 32'hA5A5_0001, r);
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL tx1_bresp: got %b, required 00", r); end
    checks++;
    if (tx_seen.size() !== 1) begin errors++; $display("FAIL tx1_count: got %0d, required 1", tx_seen.size()); end
    first = (tx_seen.size() > 0) ? tx_seen[0] : 32'hx;
    checks++;
    if (first !== 32'hA5A5_0001) begin errors++; $display("FAIL tx1_data: got %h, required a5a50001", first); end
  endtask

  task automatic test_tx_full();
    logic [1:0] r;
    logic [31:0] d;
    m_axis_tready = 1'b0;
    tx_seen.delete();
    for (int i = 0; i < 9; i++) begin
      axi_write(4'h0, 32'h100 + i, r);
      if (i == 0) begin
        checks++;
        if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 32'h100}) begin
          errors++; $display("FAIL tx_head: got %b/%h, required 1/00000100", m_axis_tvalid, m_axis_tdata);
        end
      end
      checks++;
      if (r !== (i < 8 ? 2'b00 : 2'b10)) begin
        errors++; $display("FAIL txfull_bresp[%0d]: got %b, required %b", i, r, (i < 8 ? 2'b00 : 2'b10));
      end
    end
    axi_read(4'h4, d, r);
    checks++;
    if (d !== 32'h0000_0000) begin errors++; $display("FAIL txfull_status: got %h, required 00000000", d); end
    m_axis_tready = 1'b1;
    repeat (12) @(posedge aclk);
    #1;
    m_axis_tready = 1'b0;
    checks++;
    if (tx_seen.size() !== 8) begin errors++; $display("FAIL drain_count: got %0d, required 8", tx_seen.size()); end
    for (int i = 0; i < 8 && i < tx_seen.size(); i++) begin
      checks++;
      if (tx_seen[i] !== 32'h100 + i) begin
        errors++; $display("FAIL drain_data[%0d]: got %h, required %h", i, tx_seen[i], 32'h100 + i);
      end
    end
    axi_read(4'h4, d, r);
    checks++;
    if (d !== 32'h0008_0000) begin errors++; $display("FAIL drained_status: got %h, required 00080000", d); end
  endtask

  task automatic test_rx();
    logic [1:0] r;
    logic [31:0] d;
    logic [31:0] v [3];
    v = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) rx_send(v[i]);
    axi_read(4'h4, d, r);
    checks++;
    if (d !== 32'h0008_0003) begin errors++; $display("FAIL rx_status: got %h, required 00080003", d); end
    for (int i = 0; i < 3; i++) begin
      axi_read(4'h0, d, r);
      checks++;
      if ({d, r} !== {v[i], 2'b00}) begin
        errors++; $display("FAIL rx_pop[%0d]: got %h/%b, required %h/00", i, d, r, v[i]);
      end
    end
    axi_read(4'h0, d, r);
    checks++;
    if ({d, r} !== {32'h0, 2'b10}) begin errors++; $display("FAIL rx_empty_read: got %h/%b, required 0/10", d, r); end
  endtask

  task automatic test_ctrl();
    logic [1:0] r;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) rx_send(32'h200 + i);
    checks++;
    if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rx_full_tready: got %b, required 0", s_axis_tready); end
    axi_read(4'h4, d, r);
    checks++;
    if (d !== 32'h0008_0008) begin errors++; $display("FAIL rx_full_status: got %h, required 00080008", d); end
    axi_write(4'h8, 32'h2, r);
    checks++;
    if ({r, s_axis_tready} !== 3'b001) begin
      errors++; $display("FAIL rx_flush: got bresp %b tready %b, required 00 1", r, s_axis_tready);
    end
    axi_read(4'h4, d, r);
    checks++;
    if (d !== 32'h0008_0000) begin errors++; $display("FAIL rx_flush_status: got %h, required 00080000", d); end
    axi_read(4'h8, d, r);
    checks++;
    if ({d, r} !== {32'h0, 2'b00}) begin errors++; $display("FAIL ctrl_read: got %h/%b, required 0/00", d, r); end
    axi_write(4'h0, 32'hAA, r);
    axi_write(4'h0, 32'hBB, r);
    axi_write(4'h8, 32'h1, r);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL tx_flush_tvalid: got %b, required 0", m_axis_tvalid); end
    axi_read(4'h4, d, r);
    checks++;
    if (d !== 32'h0008_0000) begin errors++; $display("FAIL tx_flush_status: got %h, required 00080000", d); end
`ifndef AXIL_AXIS_IRQ_EN
    axi_write(4'hC, 32'h1, r);
    checks++;
    if (r !== 2'b11) begin errors++; $display("FAIL decerr_write: got %b, required 11", r); end
    axi_read(4'hC, d, r);
    checks++;
    if ({d, r} !== {32'h0, 2'b11}) begin errors++; $display("FAIL decerr_read: got %h/%b, required 0/11", d, r); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [1:0] r;
    logic [31:0] d;
    m_axis_tready = 1'b0;
    @(posedge aclk); #1;
    s_axi_awaddr = 4'h0;
    s_axi_wdata = 32'h55;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid = 1'b1;
    s_axi_araddr = 4'h4;
    s_axi_arvalid = 1'b1;
    #1;
    checks++;
    if ({s_axi_awready, s_axi_arready} !== 2'b11) begin
      errors++; $display("FAIL idle_ready: got %b, required 11", {s_axi_awready, s_axi_arready});
    end
    @(posedge aclk); #1;
    s_axi_wdata = 32'h66;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_rvalid, s_axi_rresp, s_axi_arready, s_axi_rdata}
          !== {1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0008_0000}) begin
        errors++;
        $display("FAIL stall[%0d]: b %b/%b aw %b r %b/%b ar %b rdata %h, required 1/00 0 1/00 0 00080000", i,
                 s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_rvalid, s_axi_rresp, s_axi_arready, s_axi_rdata);
      end
      @(posedge aclk); #1;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b1;
    @(posedge aclk); #1;
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b0;
    #1;
    checks++;
    if ({s_axi_bvalid, s_axi_rvalid} !== 2'b00) begin
      errors++; $display("FAIL stall_release: got %b, required 00", {s_axi_bvalid, s_axi_rvalid});
    end
    axi_read(4'h4, d, r);
    checks++;
    if (d !== 32'h0007_0000) begin errors++; $display("FAIL single_accept: got %h, required 00070000", d); end
    @(posedge aclk); #1;
    s_axi_wdata = 32'h77;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    checks++;
    if ({s_axi_bvalid, m_axis_tvalid} !== 2'b11) begin
      errors++; $display("FAIL pre_abort: got %b, required 11", {s_axi_bvalid, m_axis_tvalid});
    end
    areset = 1'b1;
    #1;
    checks++;
    if ({s_axi_bvalid, m_axis_tvalid, s_axi_arready, s_axis_tready} !== 4'b0000) begin
      errors++;
      $display("FAIL abort: got %b, required 0000", {s_axi_bvalid, m_axis_tvalid, s_axi_arready, s_axis_tready});
    end
    @(posedge aclk); #1;
    areset = 1'b0;
    axi_read(4'h4, d, r);
    checks++;
    if (d !== 32'h0008_0000) begin errors++; $display("FAIL abort_status: got %h, required 00080000", d); end
  endtask

`ifdef AXIL_AXIS_IRQ_EN
  task automatic test_irq();
    logic [1:0] r;
    logic [31:0] d;
    axi_write(4'hC, 32'h1, r);
    axi_read(4'hC, d, r);
    checks++;
    if ({d, r, irq} !== {32'h1, 2'b00, 1'b0}) begin
      errors++; $display("FAIL irq_en_read: got %h/%b irq %b, required 1/00 0", d, r, irq);
    end
    rx_send(32'h99);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_push_cycle: got %b, required 0", irq); end
    @(posedge aclk); #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b, required 1", irq); end
    axi_read(4'h0, d, r);
    checks++;
    if ({d, irq} !== {32'h99, 1'b0}) begin errors++; $display("FAIL irq_clear: got %h irq %b, required 99 0", d, irq); end
    axi_write(4'hC, 32'h2, r);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_empty: got %b, required 1", irq); end
    axi_write(4'hC, 32'h0, r);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_disable: got %b, required 0", irq); end
  endtask
`endif

  initial begin
    test_reset();
    test_tx_single();
    test_tx_full();
    test_rx();
    test_ctrl();
    test_back_to_back();
`ifdef AXIL_AXIS_IRQ_EN
    test_irq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
